// File: rtl/cache_ctrl_wb_if.sv
// CPU/array/memory handshake bundle for the cache controller.
// Zero latency: this is only the wiring between the controller and its environment.
// No backpressure of its own; Strobe/DReady form the request handshake.
interface cache_ctrl_wb_if;
    // Request and lookup status, driven by the CPU and the tag/data arrays
    logic Strobe;
    logic DRW;
    logic M;
    logic V;
    logic D;
    // Controller outputs
    logic DReady;
    logic W;
    logic MStrobe;
    logic MRW;
    logic RSel;
    logic WSel;
    logic SetDirty;
    logic ClrDirty;
    logic Busy;

    modport master (
        output Strobe, DRW, M, V, D,
        input  DReady, W, MStrobe, MRW, RSel, WSel, SetDirty, ClrDirty, Busy
    );

    modport slave (
        input  Strobe, DRW, M, V, D,
        output DReady, W, MStrobe, MRW, RSel, WSel, SetDirty, ClrDirty, Busy
    );
endinterface

// File: rtl/cache_ctrl_wb.sv
// Direct-mapped cache controller: write-back or write-through, optional write-allocate.
// Latency: hit completes 1 cycle after Strobe; each memory transaction costs MEM_LAT wait cycles.
// Strobe is only accepted in IDLE; Busy signals that the CPU must hold off.
module cache_ctrl_wb #(
    parameter int WAIT_W         = 8,
    parameter int MEM_LAT        = 4,
    parameter int WRITE_BACK     = 1,
    parameter int WRITE_ALLOCATE = 1
) (
    input  logic            clk,
    input  logic            reset,
    cache_ctrl_wb_if.slave  bus
);

    // Reject latencies the counter cannot represent
    if (MEM_LAT < 1 || MEM_LAT > (2 ** WAIT_W) - 1) begin : g_lat_check
        $error("cache_ctrl_wb: MEM_LAT out of range for WAIT_W");
    end

    localparam logic [WAIT_W-1:0] LAT_LOAD = WAIT_W'(MEM_LAT - 1);
    localparam logic [WAIT_W-1:0] CNT_ONE  = WAIT_W'(1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOOKUP    = 4'd1,
        WB_REQ    = 4'd2,
        WB_WAIT   = 4'd3,
        FILL_REQ  = 4'd4,
        FILL_WAIT = 4'd5,
        FILL_DONE = 4'd6,
        WT_REQ    = 4'd7,
        WT_WAIT   = 4'd8,
        DONE      = 4'd9
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [WAIT_W-1:0] cnt;
    logic              op_wr;

    logic hit;
    logic cnt_zero;
    logic wb_en;
    logic wa_en;

    logic dready;
    logic w;
    logic mstrobe;
    logic mrw;
    logic rsel;
    logic wsel;
    logic set_dirty;
    logic clr_dirty;
    logic busy;

    assign hit      = bus.M & bus.V;
    assign cnt_zero = (cnt == '0);
    assign wb_en    = (WRITE_BACK != 0);
    assign wa_en    = (WRITE_ALLOCATE != 0);

    // State register and captured CPU operation; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            op_wr <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.Strobe) begin
                op_wr <= bus.DRW;
            end
        end
    end

    // Memory latency counter: armed in each request state, counts down to 0 while waiting
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            case (state)
                WB_REQ, FILL_REQ, WT_REQ: cnt <= LAT_LOAD;
                WB_WAIT, FILL_WAIT, WT_WAIT: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: cnt <= cnt;
            endcase
        end
    end

    // Next-state and output decode; lookup outputs depend on the live M/V/D inputs
    always_comb begin
        state_nx  = state;
        dready    = 1'b0;
        w         = 1'b0;
        mstrobe   = 1'b0;
        mrw       = 1'b0;
        rsel      = 1'b0;
        wsel      = 1'b0;
        set_dirty = 1'b0;
        clr_dirty = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.Strobe) begin
                    state_nx = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    if (!op_wr) begin
                        dready   = 1'b1;
                        state_nx = IDLE;
                    end else if (wb_en) begin
                        w         = 1'b1;
                        set_dirty = 1'b1;
                        dready    = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        w        = 1'b1;
                        state_nx = WT_REQ;
                    end
                end else if (bus.V && bus.D && wb_en) begin
                    state_nx = WB_REQ;
                end else if (!op_wr || wa_en) begin
                    state_nx = FILL_REQ;
                end else begin
                    state_nx = WT_REQ;
                end
            end
            WB_REQ: begin
                mstrobe  = 1'b1;
                mrw      = 1'b1;
                rsel     = 1'b1;
                state_nx = WB_WAIT;
            end
            WB_WAIT: begin
                mrw  = 1'b1;
                rsel = 1'b1;
                if (cnt_zero) begin
                    clr_dirty = 1'b1;
                    state_nx  = FILL_REQ;
                end
            end
            FILL_REQ: begin
                mstrobe  = 1'b1;
                state_nx = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (cnt_zero) begin
                    state_nx = FILL_DONE;
                end
            end
            FILL_DONE: begin
                w         = 1'b1;
                wsel      = 1'b1;
                clr_dirty = 1'b1;
                // A write miss replays the lookup, which now hits and performs the write
                if (op_wr) begin
                    state_nx = LOOKUP;
                end else begin
                    dready   = 1'b1;
                    state_nx = IDLE;
                end
            end
            WT_REQ: begin
                mstrobe  = 1'b1;
                mrw      = 1'b1;
                state_nx = WT_WAIT;
            end
            WT_WAIT: begin
                mrw = 1'b1;
                if (cnt_zero) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                dready   = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.DReady   = dready;
    assign bus.W        = w;
    assign bus.MStrobe  = mstrobe;
    assign bus.MRW      = mrw;
    assign bus.RSel     = rsel;
    assign bus.WSel     = wsel;
    assign bus.SetDirty = set_dirty;
    assign bus.ClrDirty = clr_dirty;
    assign bus.Busy     = busy;

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Scoreboard bench for cache_ctrl_wb across three parameter sets.
// Every cycle the selected controller shows any nonzero output is matched against the queue.
// Unexpected, mistimed or missing output cycles are reported as FAIL lines.
module tb_cache_ctrl_wb;

    localparam logic [8:0] DR = 9'h100;
    localparam logic [8:0] WE = 9'h080;
    localparam logic [8:0] MS = 9'h040;
    localparam logic [8:0] MR = 9'h020;
    localparam logic [8:0] RS = 9'h010;
    localparam logic [8:0] WS = 9'h008;
    localparam logic [8:0] SD = 9'h004;
    localparam logic [8:0] CD = 9'h002;
    localparam logic [8:0] B  = 9'h001;

    typedef struct {
        int         rel;
        logic [8:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic strobe, drw, m, v, d;
    int   sel = 0;

    exp_t  q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    t0 = 0;
    bit    mon_en = 1'b0;
    string tname = "init";

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    cache_ctrl_wb_if if0 ();
    cache_ctrl_wb_if if1 ();
    cache_ctrl_wb_if if2 ();

    assign if0.Strobe = strobe && (sel == 0);
    assign if1.Strobe = strobe && (sel == 1);
    assign if2.Strobe = strobe && (sel == 2);
    assign if0.DRW = drw;
    assign if1.DRW = drw;
    assign if2.DRW = drw;
    assign if0.M = m;
    assign if1.M = m;
    assign if2.M = m;
    assign if0.V = v;
    assign if1.V = v;
    assign if2.V = v;
    assign if0.D = d;
    assign if1.D = d;
    assign if2.D = d;

    // Write-back, write-allocate, latency 4
    cache_ctrl_wb #(.WAIT_W(8), .MEM_LAT(4), .WRITE_BACK(1), .WRITE_ALLOCATE(1)) u0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    // Write-through, no write-allocate, latency 4
    cache_ctrl_wb #(.WAIT_W(8), .MEM_LAT(4), .WRITE_BACK(0), .WRITE_ALLOCATE(0)) u1 (
        .clk(clk), .reset(reset), .bus(if1)
    );
    // Write-through, latency 1
    cache_ctrl_wb #(.WAIT_W(8), .MEM_LAT(1), .WRITE_BACK(0), .WRITE_ALLOCATE(1)) u2 (
        .clk(clk), .reset(reset), .bus(if2)
    );

    logic [8:0] o0, o1, o2, obs;
    assign o0 = {if0.DReady, if0.W, if0.MStrobe, if0.MRW, if0.RSel, if0.WSel,
                 if0.SetDirty, if0.ClrDirty, if0.Busy};
    assign o1 = {if1.DReady, if1.W, if1.MStrobe, if1.MRW, if1.RSel, if1.WSel,
                 if1.SetDirty, if1.ClrDirty, if1.Busy};
    assign o2 = {if2.DReady, if2.W, if2.MStrobe, if2.MRW, if2.RSel, if2.WSel,
                 if2.SetDirty, if2.ClrDirty, if2.Busy};
    assign obs = (sel == 1) ? o1 : (sel == 2) ? o2 : o0;

    // Monitor: any active output cycle must match the next queued expectation
    always @(negedge clk) begin
        if (mon_en && obs != 9'd0) begin
            exp_t e;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL %s_unexpected: got cycle %0d outputs %b, want no output", tname, cyc - t0, obs);
            end else begin
                e = q.pop_front();
                if (e.rel != cyc - t0 || e.vec !== obs) begin
                    bad++;
                    $display("FAIL %s: got cycle %0d outputs %b, want cycle %0d outputs %b",
                             tname, cyc - t0, obs, e.rel, e.vec);
                end
            end
        end
    end

    task automatic expect_rng(input int c0, input int c1, input logic [8:0] vv);
        for (int i = c0; i <= c1; i++) q.push_back('{rel: i, vec: vv});
    endtask

    task automatic check_drained();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing: got %0d expected output cycles never seen, want 0", tname, q.size());
            q.delete();
        end
    endtask

    // One request: lookup sees (m1,v1,d1); from cycle 2 on the arrays report (m2,v2,d2)
    task automatic run(input string name, input int s, input logic op,
                       input logic m1, input logic v1, input logic d1,
                       input logic m2, input logic v2, input logic d2, input int len);
        tname = name;
        sel = s;
        @(posedge clk); #1;
        t0 = cyc;
        strobe = 1'b1; drw = op; m = m1; v = v1; d = d1;
        @(posedge clk); #1;
        strobe = 1'b0;
        @(posedge clk); #1;
        m = m2; v = v2; d = d2;
        repeat (len + 2) @(posedge clk);
        #1;
        check_drained();
    endtask

    initial begin
        reset = 1'b0;
        strobe = 1'b0; drw = 1'b0; m = 1'b0; v = 1'b0; d = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (o0 !== 9'd0) begin bad++; $display("FAIL reset_u0: got %b want 000000000", o0); end
        total++;
        if (o1 !== 9'd0) begin bad++; $display("FAIL reset_u1: got %b want 000000000", o1); end
        total++;
        if (o2 !== 9'd0) begin bad++; $display("FAIL reset_u2: got %b want 000000000", o2); end
        reset = 1'b1;
        mon_en = 1'b1;

        // Read hit
        expect_rng(1, 1, DR | B);
        run("read_hit", 0, 1'b0, 1, 1, 0, 1, 1, 0, 1);

        // Read miss, clean victim
        expect_rng(1, 1, B);
        expect_rng(2, 2, MS | B);
        expect_rng(3, 6, B);
        expect_rng(7, 7, WE | WS | CD | DR | B);
        run("read_miss_clean", 0, 1'b0, 0, 1, 0, 1, 1, 0, 7);

        // Read miss, dirty victim written back first
        expect_rng(1, 1, B);
        expect_rng(2, 2, MS | MR | RS | B);
        expect_rng(3, 5, MR | RS | B);
        expect_rng(6, 6, MR | RS | CD | B);
        expect_rng(7, 7, MS | B);
        expect_rng(8, 11, B);
        expect_rng(12, 12, WE | WS | CD | DR | B);
        run("read_miss_dirty", 0, 1'b0, 0, 1, 1, 1, 1, 0, 12);

        // Write miss with allocate: fill, then replayed lookup hits and writes
        expect_rng(1, 1, B);
        expect_rng(2, 2, MS | B);
        expect_rng(3, 6, B);
        expect_rng(7, 7, WE | WS | CD | B);
        expect_rng(8, 8, WE | SD | DR | B);
        run("write_miss_alloc", 0, 1'b1, 0, 0, 0, 1, 1, 0, 8);

        // Write hit in write-back mode
        expect_rng(1, 1, WE | SD | DR | B);
        run("write_hit_wb", 0, 1'b1, 1, 1, 0, 1, 1, 0, 1);

        // Write-through write hit, latency 4
        expect_rng(1, 1, WE | B);
        expect_rng(2, 2, MS | MR | B);
        expect_rng(3, 6, MR | B);
        expect_rng(7, 7, DR | B);
        run("wt_write_hit_lat4", 1, 1'b1, 1, 1, 0, 1, 1, 0, 7);

        // Write-through read miss: dirty bit ignored, no write-back
        expect_rng(1, 1, B);
        expect_rng(2, 2, MS | B);
        expect_rng(3, 6, B);
        expect_rng(7, 7, WE | WS | CD | DR | B);
        run("wt_read_miss_d_ignored", 1, 1'b0, 0, 1, 1, 0, 1, 1, 7);

        // Write miss without allocate goes straight to memory
        expect_rng(1, 1, B);
        expect_rng(2, 2, MS | MR | B);
        expect_rng(3, 6, MR | B);
        expect_rng(7, 7, DR | B);
        run("write_miss_noalloc", 1, 1'b1, 0, 1, 0, 0, 1, 0, 7);

        // Write-through write hit, latency 1
        expect_rng(1, 1, WE | B);
        expect_rng(2, 2, MS | MR | B);
        expect_rng(3, 3, MR | B);
        expect_rng(4, 4, DR | B);
        run("wt_write_hit_lat1", 2, 1'b1, 1, 1, 0, 1, 1, 0, 4);

        // Back-to-back read hits with Strobe held through the first DReady
        tname = "back_to_back";
        sel = 0;
        expect_rng(1, 1, DR | B);
        expect_rng(3, 3, DR | B);
        @(posedge clk); #1;
        t0 = cyc;
        strobe = 1'b1; drw = 1'b0; m = 1'b1; v = 1'b1; d = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        strobe = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_drained();

        // Reset during the wait of a read miss aborts silently
        tname = "reset_abort";
        expect_rng(1, 1, B);
        expect_rng(2, 2, MS | B);
        expect_rng(3, 4, B);
        @(posedge clk); #1;
        t0 = cyc;
        strobe = 1'b1; drw = 1'b0; m = 1'b0; v = 1'b1; d = 1'b0;
        @(posedge clk); #1;
        strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        total++;
        if (o0 !== 9'd0) begin bad++; $display("FAIL reset_abort_outputs: got %b want 000000000", o0); end
        repeat (12) @(posedge clk);
        #1;
        check_drained();

        // Normal operation after the aborted request
        expect_rng(1, 1, DR | B);
        run("post_reset_hit", 0, 1'b0, 1, 1, 0, 1, 1, 0, 1);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_wb.md
Name: cache_ctrl_wb

Overview:
Parametrised cache controller FSM, the successor to the fixed write-through controller.
- Adds write-back with dirty-victim eviction, selectable write-allocate, and an internal memory-latency counter replacing the external wait-state module.
- Sits between the CPU strobe/handshake interface and the direct-mapped data/tag arrays and main memory.
- Drives array write enable, datapath mux selects, and memory strobe/direction.

Parameters:
- WAIT_W, 8: width of internal latency counter.
- MEM_LAT, 4: memory access latency in cycles. Legal range 1..2^WAIT_W-1; elaboration fails outside it.
- WRITE_BACK, 1: 1 = write-back with dirty tracking; 0 = write-through, D ignored.
- WRITE_ALLOCATE, 1: 1 = write miss fills line, then writes; 0 = write miss goes straight to memory.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- Strobe  in  1  CPU request valid
- DRW  in  1  CPU op: 1 = write, 0 = read
- M  in  1  tag match for current index
- V  in  1  valid bit of current line
- D  in  1  dirty bit of current line
- DReady  out  1  request complete (1-cycle pulse)
- W  out  1  cache array write enable
- MStrobe  out  1  memory request pulse
- MRW  out  1  memory direction: 1 = write, 0 = read
- RSel  out  1  memory address select: 1 = victim tag address, 0 = CPU address
- WSel  out  1  array data select: 1 = memory data, 0 = CPU data
- SetDirty  out  1  set dirty bit of current line
- ClrDirty  out  1  clear dirty bit of current line
- Busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs are Moore/Mealy combinational from state plus sampled M/V/D. Outputs not listed for a state are 0.
- Reset (reset=0 at a clock edge): next state IDLE, counter 0, op register 0. All outputs 0 the following cycle. Reset mid-operation aborts silently: no DReady, no further MStrobe.
- Op register: DRW captured on the IDLE->LOOKUP edge. Strobe and DRW are ignored outside IDLE.
- Latency counter:
  - Loaded with MEM_LAT-1 in every *_REQ state.
  - In *_WAIT it decrements; WAIT exits on the cycle the counter is 0, so each WAIT lasts exactly MEM_LAT cycles.
- IDLE: Strobe=1 -> LOOKUP; else stay.
- LOOKUP (hit = M&V):
  - Read hit: DReady=1 -> IDLE.
  - Write hit, WRITE_BACK=1: W=1, WSel=0, SetDirty=1, DReady=1 -> IDLE.
  - Write hit, WRITE_BACK=0: W=1, WSel=0 -> WT_REQ.
  - Miss with V&D&WRITE_BACK: -> WB_REQ.
  - Miss otherwise, read or WRITE_ALLOCATE=1: -> FILL_REQ.
  - Miss otherwise, write with WRITE_ALLOCATE=0: -> WT_REQ.
- WB_REQ: MStrobe=1, MRW=1, RSel=1 -> WB_WAIT.
- WB_WAIT: MRW=1, RSel=1. On counter==0: ClrDirty=1 -> FILL_REQ.
- FILL_REQ: MStrobe=1, MRW=0 -> FILL_WAIT.
- FILL_WAIT: on counter==0 -> FILL_DONE.
- FILL_DONE: W=1, WSel=1, ClrDirty=1.
  - Read op: DReady=1 -> IDLE.
  - Write op: -> LOOKUP. The replay now hits and performs the write.
- WT_REQ: MStrobe=1, MRW=1 -> WT_WAIT.
- WT_WAIT: MRW=1. On counter==0 -> DONE.
- DONE: DReady=1 -> IDLE.
- Unused encodings -> IDLE, outputs 0.
- MStrobe is exactly one cycle per memory transaction. DReady is exactly one cycle per accepted Strobe.
- Back-to-back requests: Strobe held high while DReady is asserted is accepted in the next IDLE cycle; there is no accept in the same cycle as DReady.
- SetDirty and ClrDirty are never asserted together.

Test Plan:
(cycle 0 = IDLE with Strobe=1; MEM_LAT=4 unless stated.)
1. Read hit: M=V=1, DRW=0 -> DReady at cycle 1; MStrobe never asserted; Busy high cycle 1 only.
2. Read miss, clean: M=0, V=1, D=0 -> MStrobe (MRW=0) at cycle 2; W=1, WSel=1, ClrDirty, DReady at cycle 7.
3. Read miss, dirty, WRITE_BACK=1 -> MStrobe, MRW=1, RSel=1 at cycle 2; ClrDirty at 6; fill MStrobe at 7; DReady at 12.
4. Write miss, WRITE_ALLOCATE=1, clean -> fill completes at 7 (W=1, WSel=1); at cycle 8 W=1, WSel=0, SetDirty=1, DReady=1.
5. WRITE_BACK=0, write hit -> W=1 at cycle 1; MStrobe, MRW=1 at 2; DReady at 7; SetDirty never asserted. Repeat with MEM_LAT=1 -> DReady at 4.
6. Reset (reset=0) asserted at cycle 4 of a read miss -> IDLE at cycle 5, all outputs 0, no DReady. A new read hit issued afterwards completes normally.
